openofdm_tx_sig_gen: RTL and testbench
======================================

# openofdm_tx_sig_gen

Transmit-side PHY header generator, the counterpart of the receiver's SIGNAL/HT-SIG decoding. It takes packet parameters (rate, length, HT flags) on a start pulse. It builds the legacy L-SIG field and, for HT-mixed packets, HT-SIG1/HT-SIG2 including the CRC-8. It streams the header bits one per handshake to the downstream convolutional encoder, and tags each bit with its field so the mapper can pick BPSK or QBPSK.

## Interface
Parameters: none.

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- pkt_rate  in  8  bit7 = HT; legacy: [3:0] = {R1,R2,R3,R4}; HT: [6:0] = MCS
- pkt_len  in  16  legacy PSDU length in [11:0]; HT PSDU length in [15:0]
- ht_l_len  in  12  spoofed L-SIG LENGTH for HT packets, computed upstream
- ht_aggr, ht_sgi, ht_smoothing, ht_not_sounding  in  1 each  HT-SIG2 flags
- bit_out  out  1  header bit
- bit_out_valid  out  1  bit_out is valid
- bit_out_ready  in  1  encoder accepts bit
- field_id  out  2  0 = L-SIG, 1 = HT-SIG1, 2 = HT-SIG2
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last bit is accepted
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States:
  - IDLE → L_SIG (24 bits)
  - L_SIG → HT_SIG1 (24) if HT, else → FINISH
  - HT_SIG1 → HT_SIG2 (24) → FINISH
  - FINISH → IDLE
- Inputs are latched on the accepted start. Later input changes have no effect.
- Parameter check at start. Any failure gives err, no bits, and the block stays in IDLE:
  - legacy: pkt_rate[0] (R4) must be 1, and pkt_len[11:0] must be in 1..4095
  - HT: pkt_rate[6:0] ≤ 7
- L-SIG bit order:
  - R1, R2, R3, R4
  - reserved 0
  - LENGTH[0..11], LSB first
  - even parity over the 17 preceding bits
  - 6 tail zeros
- L-SIG in HT mode: RATE = 1101 (6 Mbps), LENGTH = ht_l_len.
- HT-SIG1, LSB first: MCS[0..6], CBW = 0, HT_LENGTH[0..15].
- HT-SIG2, in order:
  - smoothing, not_sounding, reserved = 1, aggregation
  - STBC = 00, FEC = 0, SGI, Ness = 00
  - CRC c7..c0
  - 6 tail zeros
- CRC:
  - polynomial x^8+x^2+x+1
  - register initialised to all ones at the start of HT-SIG1
  - updated bit-serially over the 34 bits HT-SIG1[0..23] and HT-SIG2[0..9]
  - transmitted as the one's complement, c7 first
- The bit index counter is 5 bits. It counts 0..23 within each field and wraps to 0 on field change.

## Timing
- Reset values: bit_out = 0, bit_out_valid = 0, field_id = 0, busy = 0, done = 0, err = 0, state = IDLE, CRC = 8'hFF.
- Accepted start in cycle N: busy = 1 and bit_out_valid = 1 with the first bit (R1) in cycle N+1. Rejected start: err = 1 in cycle N+1.
- Once bit_out_valid is asserted, bit_out_valid, bit_out and field_id hold stable until bit_out_ready. The bit advances on valid & ready.
- No bubbles: with ready held high, one bit per cycle. Legacy header = 24 cycles, HT header = 72 cycles.
- Last handshake in cycle M: bit_out_valid = 0, busy = 0 and done = 1 in cycle M+1. A start in cycle M+1 is ignored; a start in M+2 is accepted.
- start while busy: ignored, with no err.
- Reset mid-packet: every output drops to its reset value immediately. No done pulse is produced.

## Structure
- Shared package holds:
  - state encoding
  - field_id constants
  - L-SIG 6 Mbps rate code 4'b1101
  - CRC polynomial 8'h07 and CRC init 8'hFF
  - field length 24
- One sub-module, openofdm_tx_crc8: bit-serial CRC-8 with init, enable and data_in inputs and an 8-bit state output.
- Header words are assembled as 24-bit shift registers loaded at field entry.

## Test plan
- Legacy, rate 4'b1101, len 100, ready = 1 → bits 1101 0 001001100000 0 000000; done 25 cycles after start; field_id = 0 throughout.
- Legacy, rate 4'b0011 (54 Mbps), len 4095 → LENGTH bits all ones, parity = 0 (14 ones); len 0 → err pulse, no valid.
- HT, MCS 7, len 1500, ht_l_len 200, sgi = 1, aggr = 1 → L-SIG carries 1101 and 200; HT-SIG1 begins 1110000 0; HT-SIG2 begins 1111 00 0 1 00; CRC matches the bench's serial model; 72 bits total; field_id steps 0 → 1 → 2.
- Backpressure: ready toggled with a random pattern during HT → bit stream identical to the ready = 1 run; outputs stable while ready = 0.
- start pulsed while busy, and changes to pkt_len mid-packet → no effect on the stream, no err.
- reset asserted at bit 40 of an HT header → outputs zero at once; a new legacy start after reset produces a correct 24-bit header.

Source files
------------

// File: rtl/openofdm_tx_sig_gen_pkg.sv
// Shared types and constants for the transmit PHY header generator.
// Also holds the helpers that assemble the L-SIG, HT-SIG1 and HT-SIG2 words.
package openofdm_tx_sig_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L_SIG,
        S_HT_SIG1,
        S_HT_SIG2,
        S_FINISH
    } state_t;

    localparam logic [1:0] FIELD_LSIG   = 2'd0;
    localparam logic [1:0] FIELD_HTSIG1 = 2'd1;
    localparam logic [1:0] FIELD_HTSIG2 = 2'd2;

    localparam logic [3:0] LSIG_RATE_6M = 4'b1101;
    localparam logic [7:0] CRC_POLY     = 8'h07;
    localparam logic [7:0] CRC_INIT     = 8'hFF;
    localparam int         FIELD_LEN    = 24;

    // Word bit 0 is transmitted first; rate is {R1,R2,R3,R4} with R1 leading.
    function automatic logic [FIELD_LEN-1:0] build_lsig(input logic [3:0] rate,
                                                       input logic [11:0] len);
        logic [FIELD_LEN-1:0] w;
        w       = '0;
        w[0]    = rate[3];
        w[1]    = rate[2];
        w[2]    = rate[1];
        w[3]    = rate[0];
        w[16:5] = len;
        w[17]   = ^w[16:0];
        return w;
    endfunction

    function automatic logic [FIELD_LEN-1:0] build_htsig1(input logic [6:0]  mcs,
                                                         input logic [15:0] ht_len);
        return {ht_len, 1'b0, mcs};
    endfunction

    // CRC slots [17:10] stay zero here; the top substitutes the live CRC.
    function automatic logic [FIELD_LEN-1:0] build_htsig2(input logic smoothing,
                                                         input logic not_sounding,
                                                         input logic aggr,
                                                         input logic sgi);
        logic [FIELD_LEN-1:0] w;
        w    = '0;
        w[0] = smoothing;
        w[1] = not_sounding;
        w[2] = 1'b1;
        w[3] = aggr;
        w[7] = sgi;
        return w;
    endfunction

endpackage

// File: rtl/openofdm_tx_crc8.sv
// Bit-serial CRC-8 (x^8+x^2+x+1) for the HT-SIG fields.
module openofdm_tx_crc8
    import openofdm_tx_sig_gen_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= {crc[6:0], 1'b0} ^ ({8{data_in ^ crc[7]}} & CRC_POLY);
        end
    end

endmodule

// File: rtl/openofdm_tx_sig_gen.sv
// Builds L-SIG and optional HT-SIG1/HT-SIG2 and streams them one bit per
// valid/ready handshake, tagging each bit with its field.
module openofdm_tx_sig_gen
    import openofdm_tx_sig_gen_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
    input  logic [11:0] ht_l_len,
    input  logic        ht_aggr,
    input  logic        ht_sgi,
    input  logic        ht_smoothing,
    input  logic        ht_not_sounding,
    output logic        bit_out,
    output logic        bit_out_valid,
    input  logic        bit_out_ready,
    output logic [1:0]  field_id,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t               state;
    logic [FIELD_LEN-1:0] shreg;
    logic [4:0]           bit_idx;
    logic                 is_ht;
    logic [6:0]           mcs;
    logic [15:0]          ht_len;
    logic                 aggr, sgi, smoothing, not_sounding;
    logic [7:0]           crc;
    logic                 fire, last_bit, crc_slot, crc_init, crc_en, params_ok;
    logic [2:0]           crc_sel;

    assign fire      = bit_out_valid & bit_out_ready;
    assign last_bit  = (bit_idx == 5'(FIELD_LEN - 1));
    assign params_ok = pkt_rate[7] ? (pkt_rate[6:0] <= 7'd7)
                                   : (pkt_rate[0] && (pkt_len[11:0] != 12'd0));

    // HT-SIG2 bits 10..17 carry the inverted CRC, c7 first; the CRC is final
    // once bit 9 has been accepted, exactly when bit 10 appears.
    assign crc_slot = (state == S_HT_SIG2) && (bit_idx >= 5'd10) && (bit_idx <= 5'd17);
    assign crc_sel  = 3'(5'd17 - bit_idx);
    assign bit_out  = crc_slot ? ~crc[crc_sel] : shreg[0];

    assign crc_init = fire && last_bit && (state == S_L_SIG) && is_ht;
    assign crc_en   = fire && ((state == S_HT_SIG1) ||
                               ((state == S_HT_SIG2) && (bit_idx < 5'd10)));

    openofdm_tx_crc8 u_crc (
        .clock   (clock),
        .reset   (reset),
        .init    (crc_init),
        .enable  (crc_en),
        .data_in (bit_out),
        .crc     (crc)
    );

    // NOTE: every register, including the latched packet parameters, is
    // cleared by reset so no output depends on pre-reset history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            is_ht         <= 1'b0;
            mcs           <= '0;
            ht_len        <= '0;
            aggr          <= 1'b0;
            sgi           <= 1'b0;
            smoothing     <= 1'b0;
            not_sounding  <= 1'b0;
            bit_out_valid <= 1'b0;
            field_id      <= FIELD_LSIG;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (params_ok) begin
                            is_ht         <= pkt_rate[7];
                            mcs           <= pkt_rate[6:0];
                            ht_len        <= pkt_len;
                            aggr          <= ht_aggr;
                            sgi           <= ht_sgi;
                            smoothing     <= ht_smoothing;
                            not_sounding  <= ht_not_sounding;
                            shreg         <= pkt_rate[7] ? build_lsig(LSIG_RATE_6M, ht_l_len)
                                                         : build_lsig(pkt_rate[3:0], pkt_len[11:0]);
                            bit_idx       <= '0;
                            bit_out_valid <= 1'b1;
                            busy          <= 1'b1;
                            field_id      <= FIELD_LSIG;
                            state         <= S_L_SIG;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_L_SIG, S_HT_SIG1, S_HT_SIG2: begin
                    if (fire) begin
                        if (!last_bit) begin
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 5'd1;
                        end else begin
                            bit_idx <= '0;
                            if ((state == S_L_SIG) && is_ht) begin
                                shreg    <= build_htsig1(mcs, ht_len);
                                field_id <= FIELD_HTSIG1;
                                state    <= S_HT_SIG1;
                            end else if (state == S_HT_SIG1) begin
                                shreg    <= build_htsig2(smoothing, not_sounding, aggr, sgi);
                                field_id <= FIELD_HTSIG2;
                                state    <= S_HT_SIG2;
                            end else begin
                                shreg         <= '0;
                                bit_out_valid <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                field_id      <= FIELD_LSIG;
                                state         <= S_FINISH;
                            end
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_openofdm_tx_sig_gen.sv
// Scoreboard bench for openofdm_tx_sig_gen: expected header bits are queued
// from a bench-side model when a packet is started and popped per handshake.
module tb_openofdm_tx_sig_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pkt_rate;
    logic [15:0] pkt_len;
    logic [11:0] ht_l_len;
    logic        ht_aggr, ht_sgi, ht_smoothing, ht_not_sounding;
    logic        bit_out, bit_out_valid, bit_out_ready;
    logic [1:0]  field_id;
    logic        busy, done, err;

    typedef struct {
        logic       b;
        logic [1:0] f;
    } exp_t;

    exp_t         sbq[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] ht_ref;

    openofdm_tx_sig_gen dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .pkt_rate        (pkt_rate),
        .pkt_len         (pkt_len),
        .ht_l_len        (ht_l_len),
        .ht_aggr         (ht_aggr),
        .ht_sgi          (ht_sgi),
        .ht_smoothing    (ht_smoothing),
        .ht_not_sounding (ht_not_sounding),
        .bit_out         (bit_out),
        .bit_out_valid   (bit_out_valid),
        .bit_out_ready   (bit_out_ready),
        .field_id        (field_id),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic set_pkt(input logic [7:0] rate, input logic [15:0] len,
                           input logic [11:0] l_len, input logic aggr,
                           input logic sgi, input logic sm, input logic ns);
        pkt_rate        = rate;
        pkt_len         = len;
        ht_l_len        = l_len;
        ht_aggr         = aggr;
        ht_sgi          = sgi;
        ht_smoothing    = sm;
        ht_not_sounding = ns;
    endtask

    task automatic push_exp(input logic b, input logic [1:0] f);
        exp_t e;
        e.b = b;
        e.f = f;
        sbq.push_back(e);
    endtask

    // Reference model of the header bit stream, written as a flat bit sequence.
    task automatic push_expected(input logic [7:0] rate, input logic [15:0] len,
                                 input logic [11:0] l_len, input logic aggr,
                                 input logic sgi, input logic sm, input logic ns);
        logic [3:0]  r;
        logic [11:0] ll;
        logic        par, fb;
        logic [7:0]  c;
        logic [33:0] hs;
        if (rate[7]) begin
            r  = 4'b1101;
            ll = l_len;
        end else begin
            r  = rate[3:0];
            ll = len[11:0];
        end
        par = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            push_exp(r[i], 2'd0);
            par ^= r[i];
        end
        push_exp(1'b0, 2'd0);
        for (int i = 0; i < 12; i++) begin
            push_exp(ll[i], 2'd0);
            par ^= ll[i];
        end
        push_exp(par, 2'd0);
        for (int i = 0; i < 6; i++) push_exp(1'b0, 2'd0);
        if (rate[7]) begin
            hs        = '0;
            hs[6:0]   = rate[6:0];
            hs[23:8]  = len;
            hs[24]    = sm;
            hs[25]    = ns;
            hs[26]    = 1'b1;
            hs[27]    = aggr;
            hs[31]    = sgi;
            c = 8'hFF;
            for (int i = 0; i < 34; i++) begin
                push_exp(hs[i], (i < 24) ? 2'd1 : 2'd2);
                fb = hs[i] ^ c[7];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
            for (int i = 7; i >= 0; i--) push_exp(~c[i], 2'd2);
            for (int i = 0; i < 6; i++) push_exp(1'b0, 2'd2);
        end
    endtask

    // Runs from posedge+1 of the cycle after the accepted start; cycle 1 is
    // the first cycle in which bit_out_valid should be high.
    task automatic run_stream(input int mode, input int disturb_at, input int stop_bits,
                              output int done_cyc, output logic [127:0] got,
                              output int nbits);
        logic pv, pr, pb;
        logic [1:0] pf;
        bit finished, err_seen;
        exp_t e;
        got = '0; nbits = 0; done_cyc = -1;
        pv = 1'b0; pr = 1'b0; pb = 1'b0; pf = 2'd0;
        finished = 1'b0; err_seen = 1'b0;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            bit_out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (cyc == disturb_at) begin
                start   = 1'b1;
                pkt_len = 16'd7;
            end else if (cyc == disturb_at + 1) begin
                start = 1'b0;
            end
            @(negedge clock);
            if (err) err_seen = 1'b1;
            if (pv && !pr) begin
                n_tests++;
                if (bit_out_valid !== 1'b1 || bit_out !== pb || field_id !== pf) begin
                    n_fail++;
                    $display("FAIL hold cyc%0d: valid=%b bit=%b fid=%0d, required valid=1 bit=%b fid=%0d",
                             cyc, bit_out_valid, bit_out, field_id, pb, pf);
                end
            end
            if (bit_out_valid && bit_out_ready) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_bit %0d: bit=%b, required no bit", nbits, bit_out);
                end else begin
                    e = sbq.pop_front();
                    if (bit_out !== e.b || field_id !== e.f || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bit%0d: bit=%b fid=%0d busy=%b, required bit=%b fid=%0d busy=1",
                                 nbits, bit_out, field_id, busy, e.b, e.f);
                    end
                end
                got[nbits] = bit_out;
                nbits++;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
                n_tests++;
                if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_state: valid=%b busy=%b, required 0 0", bit_out_valid, busy);
                end
            end else if (stop_bits > 0 && nbits == stop_bits) begin
                finished = 1'b1;
            end
            pv = bit_out_valid; pr = bit_out_ready; pb = bit_out; pf = field_id;
            if (!finished) begin
                @(posedge clock);
                #1;
            end
        end
        n_tests++;
        if (!finished || err_seen) begin
            n_fail++;
            $display("FAIL stream_end: finished=%b err_seen=%b, required 1 0", finished, err_seen);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bit_out, bit_out_valid, field_id, busy, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got %b, required 0000000",
                     {bit_out, bit_out_valid, field_id, busy, done, err});
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bit_out, bit_out_valid, field_id, busy, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b, required 0000000",
                     {bit_out, bit_out_valid, field_id, busy, done, err});
        end
    endtask

    task automatic test_legacy_basic();
        int dc, nb;
        logic [127:0] got;
        logic [23:0] exp_w;
        exp_w = {6'b0, 1'b0, 12'b000001100100, 1'b0, 4'b1011};
        align();
        set_pkt(8'h0D, 16'd100, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_expected(8'h0D, 16'd100, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run_stream(0, 0, 0, dc, got, nb);
        n_tests++;
        if (got[23:0] !== exp_w || nb != 24) begin
            n_fail++;
            $display("FAIL legacy_word: got %h (%0d bits), required %h (24 bits)", got[23:0], nb, exp_w);
        end
        n_tests++;
        if (dc != 25) begin
            n_fail++;
            $display("FAIL legacy_done_latency: got %0d, required 25", dc);
        end
    endtask

    task automatic test_legacy_max();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h03, 16'd4095, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_expected(8'h03, 16'd4095, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run_stream(0, 0, 0, dc, got, nb);
        n_tests++;
        if (got[16:5] !== 12'hFFF || got[17] !== 1'b0 || got[3:0] !== 4'b1100) begin
            n_fail++;
            $display("FAIL legacy_max: len=%h par=%b rate=%b, required fff 0 1100",
                     got[16:5], got[17], got[3:0]);
        end
    endtask

    task automatic test_reject();
        logic [7:0] rt;
        for (int k = 0; k < 3; k++) begin
            rt = (k == 0) ? 8'h03 : (k == 1) ? 8'h0C : 8'h88;
            align();
            set_pkt(rt, (k == 0) ? 16'd0 : 16'd100, 12'd50, 1'b0, 1'b0, 1'b0, 1'b0);
            pulse_start();
            @(negedge clock);
            n_tests++;
            if (err !== 1'b1 || bit_out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reject%0d: err=%b valid=%b busy=%b, required 1 0 0",
                         k, err, bit_out_valid, busy);
            end
            align();
            @(negedge clock);
            n_tests++;
            if (err !== 1'b0 || bit_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reject%0d_after: err=%b valid=%b, required 0 0", k, err, bit_out_valid);
            end
        end
    endtask

    task automatic test_ht();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h87, 16'd1500, 12'd200, 1'b1, 1'b1, 1'b1, 1'b1);
        push_expected(8'h87, 16'd1500, 12'd200, 1'b1, 1'b1, 1'b1, 1'b1);
        pulse_start();
        run_stream(0, 0, 0, dc, got, nb);
        ht_ref = got;
        n_tests++;
        if (got[3:0] !== 4'b1011 || got[16:5] !== 12'd200) begin
            n_fail++;
            $display("FAIL ht_lsig: rate=%b len=%0d, required 1011 200", got[3:0], got[16:5]);
        end
        n_tests++;
        if (got[31:24] !== 8'b00000111 || got[57:48] !== 10'b0010001111) begin
            n_fail++;
            $display("FAIL ht_sig_heads: sig1=%b sig2=%b, required 00000111 0010001111",
                     got[31:24], got[57:48]);
        end
        n_tests++;
        if (nb != 72 || dc != 73) begin
            n_fail++;
            $display("FAIL ht_length: bits=%0d done_cyc=%0d, required 72 73", nb, dc);
        end
    endtask

    task automatic test_backpressure();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h87, 16'd1500, 12'd200, 1'b1, 1'b1, 1'b1, 1'b1);
        push_expected(8'h87, 16'd1500, 12'd200, 1'b1, 1'b1, 1'b1, 1'b1);
        pulse_start();
        run_stream(1, 0, 0, dc, got, nb);
        bit_out_ready = 1'b1;
        n_tests++;
        if (got[71:0] !== ht_ref[71:0] || nb != 72) begin
            n_fail++;
            $display("FAIL backpressure_stream: got %h (%0d bits), required %h",
                     got[71:0], nb, ht_ref[71:0]);
        end
    endtask

    task automatic test_start_while_busy();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h0B, 16'd300, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_expected(8'h0B, 16'd300, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run_stream(0, 5, 0, dc, got, nb);
        n_tests++;
        if (sbq.size() != 0 || dc != 25) begin
            n_fail++;
            $display("FAIL busy_start: left=%0d done_cyc=%0d, required 0 25", sbq.size(), dc);
        end
        align();
        @(negedge clock);
        n_tests++;
        if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_relaunch: valid=%b busy=%b, required 0 0", bit_out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h0F, 16'd55, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_expected(8'h0F, 16'd55, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run_stream(0, 0, 0, dc, got, nb);
        // Now at the negedge of the done cycle: raise start for two cycles.
        set_pkt(8'h09, 16'd2222, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        align();
        @(negedge clock);
        n_tests++;
        if (bit_out_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored: valid=%b err=%b busy=%b, required 0 0 0",
                     bit_out_valid, err, busy);
        end
        push_expected(8'h09, 16'd2222, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        align();
        start = 1'b0;
        run_stream(0, 0, 0, dc, got, nb);
        n_tests++;
        if (dc != 25 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_second: done_cyc=%0d left=%0d, required 25 0", dc, sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        int dc, nb;
        logic [127:0] got;
        align();
        set_pkt(8'h85, 16'd900, 12'd120, 1'b0, 1'b1, 1'b0, 1'b1);
        push_expected(8'h85, 16'd900, 12'd120, 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        run_stream(0, 0, 40, dc, got, nb);
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bit_out, bit_out_valid, field_id, busy, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b, required 0000000",
                     {bit_out, bit_out_valid, field_id, busy, done, err});
        end
        sbq.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (done !== 1'b0 || bit_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: done=%b valid=%b, required 0 0", done, bit_out_valid);
        end
        align();
        set_pkt(8'h09, 16'd1234, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_expected(8'h09, 16'd1234, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        run_stream(0, 0, 0, dc, got, nb);
        n_tests++;
        if (dc != 25 || nb != 24 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: done_cyc=%0d bits=%0d left=%0d, required 25 24 0",
                     dc, nb, sbq.size());
        end
    endtask

    initial begin
        start         = 1'b0;
        bit_out_ready = 1'b1;
        set_pkt(8'h00, 16'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_legacy_basic();
        test_legacy_max();
        test_reject();
        test_ht();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
